// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control FSM for the FullDMRFALU datapath.
// Accepts one MIPS instruction per valid/ready handshake in IDLE, then walks
// DECODE -> EXEC -> (MEM) -> (WB) issuing one-cycle register/memory strobes.
// Field outputs are slices of the latched instruction register.
module multicycle_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 16,
  parameter int ADDI_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              Zero,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [IMM_W-1:0]  SEin,
  output logic [5:0]        FuncCode,
  output logic              Regsel,
  output logic              ALUsel,
  output logic [1:0]        ALUOp,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemToRegSel,
  output logic              RegWrite,
  output logic              done,
  output logic              branch_taken,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  state_t      state_reg, state_next;
  logic [31:0] ir_reg;

  logic [5:0] opcode;
  logic       is_r, is_lw, is_sw, is_addi, is_beq, is_legal;

  // State register and instruction latch; IR only loads on an IDLE handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ir_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && instr_valid)
        ir_reg <= instr;
    end
  end

  // Opcode classification of the latched instruction
  always_comb begin
    opcode   = ir_reg[31:26];
    is_r     = (opcode == OP_RTYPE);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_addi  = (opcode == OP_ADDI) && (ADDI_EN != 0);
    is_beq   = (opcode == OP_BEQ);
    is_legal = is_r | is_lw | is_sw | is_addi | is_beq;
  end

  assign rs          = REG_AW'(ir_reg[25:21]);
  assign rt          = REG_AW'(ir_reg[20:16]);
  assign rd          = REG_AW'(ir_reg[15:11]);
  assign SEin        = IMM_W'(ir_reg[15:0]);
  assign FuncCode    = ir_reg[5:0];
  assign instr_ready = (state_reg == S_IDLE);

  // Moore datapath selects: stable for the whole instruction, zero in IDLE
  always_comb begin
    Regsel      = 1'b0;
    ALUsel      = 1'b0;
    ALUOp       = 2'b00;
    MemToRegSel = 1'b0;
    if (state_reg != S_IDLE) begin
      if (is_r) begin
        Regsel = 1'b1;
        ALUOp  = 2'b10;
      end else if (is_lw || is_sw || is_addi) begin
        ALUsel = 1'b1;
      end else if (is_beq) begin
        ALUOp  = 2'b01;
      end
      MemToRegSel = is_lw;
    end
  end

  // Next-state sequencing and one-cycle strobes
  always_comb begin
    state_next   = state_reg;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (instr_valid)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else begin
          illegal    = 1'b1;
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_EXEC: begin
        if (is_r || is_addi) begin
          state_next = S_WB;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          // beq finishes here with the datapath compare result
          branch_taken = is_beq & Zero;
          done         = 1'b1;
          state_next   = S_IDLE;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          MemRead    = 1'b1;
          state_next = S_WB;
        end else begin
          MemWrite   = is_sw;
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed, table-driven bench for multicycle_ctrl_unit. A second instance
// with ADDI_EN=0 shares the stimulus to cover the addi-disabled decode.
module tb_multicycle_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        Zero;

  logic       instr_ready, Regsel, ALUsel, MemRead, MemWrite, MemToRegSel;
  logic       RegWrite, done, branch_taken, illegal;
  logic [4:0] rs, rt, rd;
  logic [15:0] SEin;
  logic [5:0] FuncCode;
  logic [1:0] ALUOp;

  logic       n_instr_ready, n_Regsel, n_ALUsel, n_MemRead, n_MemWrite, n_MemToRegSel;
  logic       n_RegWrite, n_done, n_branch_taken, n_illegal;
  logic [4:0] n_rs, n_rt, n_rd;
  logic [15:0] n_SEin;
  logic [5:0] n_FuncCode;
  logic [1:0] n_ALUOp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Zero(Zero), .rs(rs), .rt(rt), .rd(rd),
    .SEin(SEin), .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel),
    .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToRegSel(MemToRegSel), .RegWrite(RegWrite), .done(done),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  multicycle_ctrl_unit #(.ADDI_EN(0)) dut_noaddi (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(n_instr_ready), .Zero(Zero), .rs(n_rs), .rt(n_rt), .rd(n_rd),
    .SEin(n_SEin), .FuncCode(n_FuncCode), .Regsel(n_Regsel), .ALUsel(n_ALUsel),
    .ALUOp(n_ALUOp), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .MemToRegSel(n_MemToRegSel), .RegWrite(n_RegWrite), .done(n_done),
    .branch_taken(n_branch_taken), .illegal(n_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          lat;      // accept edge to done cycle
    logic        regsel;
    logic        alusel;
    logic [1:0]  aluop;
    logic        m2r;
    int          rd_cyc;   // cycle of MemRead, 0 = never
    int          wr_cyc;   // cycle of MemWrite, 0 = never
    int          rw_cyc;   // cycle of RegWrite, 0 = never
    logic        br;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Offer one instruction at a negedge while IDLE and check it cycle by cycle;
  // returns on the negedge where instr_ready is back.
  task automatic run_vec(input vec_t v, input int idx);
    instr       = v.instr;
    Zero        = v.zero;
    instr_valid = 1'b1;
    chk($sformatf("v%0d ready_pre", idx), {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (k == 1) begin
        chk($sformatf("v%0d rs", idx), {27'd0, rs}, {27'd0, v.instr[25:21]});
        chk($sformatf("v%0d rt", idx), {27'd0, rt}, {27'd0, v.instr[20:16]});
        chk($sformatf("v%0d rd", idx), {27'd0, rd}, {27'd0, v.instr[15:11]});
        chk($sformatf("v%0d SEin", idx), {16'd0, SEin}, {16'd0, v.instr[15:0]});
        chk($sformatf("v%0d FuncCode", idx), {26'd0, FuncCode}, {26'd0, v.instr[5:0]});
      end
      chk($sformatf("v%0d c%0d ready", idx, k), {31'd0, instr_ready}, 32'd0);
      chk($sformatf("v%0d c%0d Regsel", idx, k), {31'd0, Regsel}, {31'd0, v.regsel});
      chk($sformatf("v%0d c%0d ALUsel", idx, k), {31'd0, ALUsel}, {31'd0, v.alusel});
      chk($sformatf("v%0d c%0d ALUOp", idx, k), {30'd0, ALUOp}, {30'd0, v.aluop});
      chk($sformatf("v%0d c%0d MemToRegSel", idx, k), {31'd0, MemToRegSel}, {31'd0, v.m2r});
      chk($sformatf("v%0d c%0d MemRead", idx, k), {31'd0, MemRead}, {31'd0, (k == v.rd_cyc)});
      chk($sformatf("v%0d c%0d MemWrite", idx, k), {31'd0, MemWrite}, {31'd0, (k == v.wr_cyc)});
      chk($sformatf("v%0d c%0d RegWrite", idx, k), {31'd0, RegWrite}, {31'd0, (k == v.rw_cyc)});
      chk($sformatf("v%0d c%0d done", idx, k), {31'd0, done}, {31'd0, (k == v.lat)});
      chk($sformatf("v%0d c%0d branch_taken", idx, k), {31'd0, branch_taken},
          {31'd0, (k == v.lat) && v.br});
      chk($sformatf("v%0d c%0d illegal", idx, k), {31'd0, illegal},
          {31'd0, (k == v.lat) && v.ill});
    end
    @(negedge clk);
    chk($sformatf("v%0d ready_post", idx), {31'd0, instr_ready}, 32'd1);
    chk($sformatf("v%0d idle_strobes", idx), {29'd0, MemRead, MemWrite, RegWrite}, 32'd0);
    chk($sformatf("v%0d idle_done", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d rd_held", idx), {27'd0, rd}, {27'd0, v.instr[15:11]});
    $display("txn %0d instr=%08h lat=%0d br=%0b ill=%0b", idx, v.instr, v.lat, v.br, v.ill);
  endtask

  initial begin
    //            instr         z  lat rs al op  m2r rd wr rw br ill
    vecs[0] = '{32'h00221820, 0, 3, 1, 0, 2'b10, 0, 0, 0, 3, 0, 0}; // add
    vecs[1] = '{32'h8C430014, 0, 4, 0, 1, 2'b00, 1, 3, 0, 4, 0, 0}; // lw
    vecs[2] = '{32'hAC430028, 0, 3, 0, 1, 2'b00, 0, 0, 3, 0, 0, 0}; // sw
    vecs[3] = '{32'h10220004, 1, 2, 0, 0, 2'b01, 0, 0, 0, 0, 1, 0}; // beq taken
    vecs[4] = '{32'h10220004, 0, 2, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0}; // beq not taken
    vecs[5] = '{32'hFC000000, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1}; // opcode 111111
    vecs[6] = '{32'h20010005, 0, 3, 0, 1, 2'b00, 0, 0, 0, 3, 0, 0}; // addi
    vecs[7] = '{32'h00432022, 0, 3, 1, 0, 2'b10, 0, 0, 0, 3, 0, 0}; // sub

    // Reset held with an instruction offered: nothing is accepted
    rst         = 1'b1;
    instr       = 32'h00221820;
    instr_valid = 1'b1;
    Zero        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst ready", {31'd0, instr_ready}, 32'd1);
      chk("rst strobes", {25'd0, MemRead, MemWrite, RegWrite, done, illegal, branch_taken, Regsel}, 32'd0);
      chk("rst rs", {27'd0, rs}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("post_rst ready", {31'd0, instr_ready}, 32'd0);
    chk("post_rst rs", {27'd0, rs}, 32'd1);
    chk("post_rst rt", {27'd0, rt}, 32'd2);
    chk("post_rst rd", {27'd0, rd}, 32'd3);
    chk("post_rst FuncCode", {26'd0, FuncCode}, 32'h20);
    chk("post_rst Regsel", {31'd0, Regsel}, 32'd1);
    chk("post_rst ALUOp", {30'd0, ALUOp}, 32'd2);
    @(negedge clk);
    chk("post_rst c2 RegWrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    chk("post_rst c3 RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("post_rst c3 done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("post_rst ready_back", {31'd0, instr_ready}, 32'd1);
    $display("txn reset-accept instr=00221820");

    // Table-driven vectors, issued back to back
    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], i);

    // addi against the ADDI_EN=0 instance: flagged illegal in DECODE
    instr       = 32'h20010005;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("noaddi c1 illegal", {31'd0, n_illegal}, 32'd1);
    chk("noaddi c1 done", {31'd0, n_done}, 32'd1);
    chk("noaddi c1 strobes", {29'd0, n_MemRead, n_MemWrite, n_RegWrite}, 32'd0);
    chk("addi c1 illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    chk("noaddi c2 ready", {31'd0, n_instr_ready}, 32'd1);
    chk("noaddi c2 illegal", {31'd0, n_illegal}, 32'd0);
    @(negedge clk);
    chk("addi c3 RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("noaddi c3 RegWrite", {31'd0, n_RegWrite}, 32'd0);
    @(negedge clk);
    chk("addi ready_back", {31'd0, instr_ready}, 32'd1);
    $display("txn addi-disabled instr=20010005 illegal=1");

    // Reset asserted while lw sits in MEM: abort at once, no writeback
    instr       = 32'h8C430014;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort MemRead_before", {31'd0, MemRead}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort ready", {31'd0, instr_ready}, 32'd1);
    chk("abort MemRead", {31'd0, MemRead}, 32'd0);
    chk("abort rs", {27'd0, rs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort idle%0d RegWrite", i), {31'd0, RegWrite}, 32'd0);
      chk($sformatf("abort idle%0d ready", i), {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
    end
    $display("txn lw-abort instr=8C430014");

    // Back-to-back R-type then sw after the abort
    run_vec(vecs[0], 10);
    run_vec(vecs[2], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
